// File: rtl/ad9361_cal_monitor.sv
// AD9361 calibration sequencer/monitor: reset hold, ordered stage tracking with timeout retry, LED/status map.
// Optional per-stage latency readback when AD9361_CAL_MON_LAT_EN is defined.
module ad9361_cal_monitor #(
  parameter int NUM_STAGES  = 7,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int RST_CYC     = 1000,
  parameter int MAX_RETRY   = 2,
  parameter int BLINK_DIV   = 12_500_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  resetb,
  output logic                  spi_restart,
  output logic [NUM_STAGES-1:0] led,
  output logic [3:0]            cur_stage,
  output logic [3:0]            retry_cnt,
  output logic                  cfg_ok,
  output logic                  cfg_err,
  input  logic [3:0]            stage_sel,
  output logic [31:0]           stage_lat
);

  localparam int MAX_CYC = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    WAIT     = 2'd1,
    DONE     = 2'd2,
    FAIL     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [NUM_STAGES-1:0] latch_q, latch_d;
  logic [3:0]            cur_q, cur_d;
  logic [3:0]            retry_q, retry_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  blink_q, blink_d;
  logic                  resetb_q, resetb_d;
  logic                  spi_q, spi_d;
  logic [NUM_STAGES-1:0] led_q, led_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  logic [NUM_STAGES-1:0] sel_mask, next_mask, below_mask;
  logic                  hit;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= RST_HOLD;
      timer_q  <= '0;
      latch_q  <= '0;
      cur_q    <= 4'd0;
      retry_q  <= 4'd0;
      bcnt_q   <= '0;
      blink_q  <= 1'b0;
      resetb_q <= 1'b0;
      spi_q    <= 1'b0;
      led_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      latch_q  <= latch_d;
      cur_q    <= cur_d;
      retry_q  <= retry_d;
      bcnt_q   <= bcnt_d;
      blink_q  <= blink_d;
      resetb_q <= resetb_d;
      spi_q    <= spi_d;
      led_q    <= led_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    latch_d = latch_q | stage_done;
    cur_d   = cur_q;
    retry_d = retry_q;
    bcnt_d  = bcnt_q + BW'(1);
    blink_d = blink_q;
    led_d   = '0;

    if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end else begin
      bcnt_d  = bcnt_q + BW'(1);
    end

    // A stage is satisfied by a flag latched earlier or one arriving this cycle
    sel_mask = NUM_STAGES'(1) << cur_q;
    hit      = |((latch_q | stage_done) & sel_mask);

    case (state_q)
      RST_HOLD: begin
        latch_d = '0;
        cur_d   = 4'd0;
        if (timer_q == TW'(RST_CYC - 1)) begin
          timer_d = '0;
          state_d = WAIT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT: begin
        if (hit) begin
          timer_d = '0;
          if (cur_q == 4'(NUM_STAGES - 1)) begin
            state_d = DONE;
          end else begin
            cur_d = cur_q + 4'd1;
          end
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_d = retry_q + 4'd1;
            timer_d = '0;
            state_d = RST_HOLD;
          end else begin
            state_d = FAIL;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RST_HOLD;
      end
    endcase

    next_mask  = NUM_STAGES'(1) << cur_d;
    below_mask = next_mask - NUM_STAGES'(1);
    case (state_d)
      RST_HOLD: led_d = '0;
      DONE:     led_d = '1;
      default:  led_d = below_mask | (blink_d ? next_mask : '0);
    endcase

    resetb_d = (state_d != RST_HOLD);
    spi_d    = (state_q == RST_HOLD) && (state_d == WAIT);
    ok_d     = (state_d == DONE);
    err_d    = (state_d == FAIL);
  end

  assign resetb      = resetb_q;
  assign spi_restart = spi_q;
  assign led         = led_q;
  assign cur_stage   = cur_q;
  assign retry_cnt   = retry_q;
  assign cfg_ok      = ok_q;
  assign cfg_err     = err_q;

`ifdef AD9361_CAL_MON_LAT_EN
  logic [31:0] lat_q [NUM_STAGES];
  logic [31:0] lat_d [NUM_STAGES];
  logic [31:0] rd_q, rd_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int k = 0; k < NUM_STAGES; k++) lat_q[k] <= 32'd0;
      rd_q <= 32'd0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) lat_q[k] <= lat_d[k];
      rd_q <= rd_d;
    end
  end

  // Latency is the number of WAIT cycles spent on the stage, hit cycle included
  always_comb begin
    rd_d = 32'd0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      lat_d[k] = lat_q[k];
      if (state_q == RST_HOLD) begin
        lat_d[k] = 32'd0;
      end else if ((state_q == WAIT) && hit && (cur_q == 4'(k))) begin
        lat_d[k] = 32'(timer_q) + 32'd1;
      end else begin
        lat_d[k] = lat_q[k];
      end
      if (stage_sel == 4'(k)) begin
        rd_d = lat_q[k];
      end else begin
        rd_d = rd_d;
      end
    end
  end

  assign stage_lat = rd_q;
`else
  logic unused_stage_sel;
  assign unused_stage_sel = ^stage_sel;
  assign stage_lat        = 32'd0;
`endif

endmodule

// File: tb/tb_ad9361_cal_monitor.sv
// Randomised + directed bench for ad9361_cal_monitor against a cycle-level reference model.
module tb_ad9361_cal_monitor;
  localparam int NS = 4;
  localparam int TO = 100;
  localparam int RC = 8;
  localparam int MR = 1;
  localparam int BD = 4;
  localparam int P_HOLD = 0, P_WAIT = 1, P_DONE = 2, P_FAIL = 3;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic [NS-1:0] stage_done;
  logic          resetb, spi_restart, cfg_ok, cfg_err;
  logic [NS-1:0] led;
  logic [3:0]    cur_stage, retry_cnt, stage_sel;
  logic [31:0]   stage_lat;

  always #5 clk = ~clk;

  ad9361_cal_monitor #(
    .NUM_STAGES(NS), .TIMEOUT_CYC(TO), .RST_CYC(RC), .MAX_RETRY(MR), .BLINK_DIV(BD)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .stage_done(stage_done), .resetb(resetb),
    .spi_restart(spi_restart), .led(led), .cur_stage(cur_stage), .retry_cnt(retry_cnt),
    .cfg_ok(cfg_ok), .cfg_err(cfg_err), .stage_sel(stage_sel), .stage_lat(stage_lat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase, per-stage cycle counter, completed stage count
  int m_phase, m_timer, m_stage, m_retry, m_bcnt, m_blink, m_spi, m_rd;
  bit m_latched [NS];
  int m_lat [NS];

  task automatic model_step();
    bit h;
    if (sys_rst) begin
      m_phase = P_HOLD; m_timer = 0; m_stage = 0; m_retry = 0;
      m_bcnt = 0; m_blink = 0; m_spi = 0; m_rd = 0;
      for (int i = 0; i < NS; i++) begin m_latched[i] = 0; m_lat[i] = 0; end
      return;
    end
    m_rd = (stage_sel < NS) ? m_lat[stage_sel] : 0;
    m_bcnt = m_bcnt + 1;
    if (m_bcnt == BD) begin m_bcnt = 0; m_blink = 1 - m_blink; end
    m_spi = 0;
    if (m_phase == P_HOLD) begin
      for (int i = 0; i < NS; i++) begin m_latched[i] = 0; m_lat[i] = 0; end
      m_stage = 0;
      m_timer = m_timer + 1;
      if (m_timer == RC) begin m_timer = 0; m_phase = P_WAIT; m_spi = 1; end
    end else begin
      h = m_latched[m_stage] | stage_done[m_stage];
      for (int i = 0; i < NS; i++) m_latched[i] = m_latched[i] | stage_done[i];
      if (m_phase == P_WAIT) begin
        if (h) begin
          m_lat[m_stage] = m_timer + 1;
          m_timer = 0;
          if (m_stage == NS - 1) m_phase = P_DONE;
          else m_stage = m_stage + 1;
        end else if (m_timer == TO - 1) begin
          if (m_retry < MR) begin m_retry++; m_timer = 0; m_phase = P_HOLD; end
          else m_phase = P_FAIL;
        end else begin
          m_timer = m_timer + 1;
        end
      end
    end
  endtask

  function automatic logic [NS-1:0] exp_led();
    logic [NS-1:0] v;
    v = '0;
    if (m_phase == P_DONE) v = '1;
    else if (m_phase != P_HOLD) begin
      for (int i = 0; i < NS; i++) if (i < m_stage) v[i] = 1'b1;
      v[m_stage] = (m_blink != 0);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("resetb", 32'(resetb), 32'(m_phase != P_HOLD));
    check_val("spi_restart", 32'(spi_restart), 32'(m_spi));
    check_val("led", 32'(led), 32'(exp_led()));
    check_val("cur_stage", 32'(cur_stage), 32'(m_stage));
    check_val("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    check_val("cfg_ok", 32'(cfg_ok), 32'(m_phase == P_DONE));
    check_val("cfg_err", 32'(cfg_err), 32'(m_phase == P_FAIL));
`ifdef AD9361_CAL_MON_LAT_EN
    check_val("stage_lat", stage_lat, 32'(m_rd));
`else
    check_val("stage_lat", stage_lat, 32'd0);
`endif
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    repeat (n) tick();
    sys_rst = 1'b0;
  endtask

  task automatic wait_release();
    int k = 0;
    while (resetb !== 1'b1 && k < 50) begin tick(); k++; end
    check_val("release_bound", 32'(resetb), 32'd1);
  endtask

  task automatic pulse(input logic [NS-1:0] b);
    stage_done = b;
    tick();
    stage_done = '0;
  endtask

  initial begin
    int low, spis, k, tog;
    logic prev;
    sys_rst = 1'b1; stage_done = '0; stage_sel = 4'd0;

    // Reset then idle
    do_reset(2);
    low = (resetb === 1'b0) ? 1 : 0; spis = 0;
    repeat (20) begin tick(); if (resetb === 1'b0) low++; if (spi_restart === 1'b1) spis++; end
    check_val("rst_low_cycles", 32'(low), 32'd8);
    check_val("spi_pulses", 32'(spis), 32'd1);

    // In-order pulses 10 cycles apart
    do_reset(1); wait_release(); repeat (3) tick();
    for (int b = 0; b < NS; b++) begin
      pulse(NS'(1) << b);
      check_val("led_fill", 32'(led & NS'((1 << (b + 1)) - 1)), 32'((1 << (b + 1)) - 1));
      if (b < NS - 1) repeat (9) tick();
    end
    check_val("ok_after_last", 32'(cfg_ok), 32'd1);
    check_val("ok_cur_stage", 32'(cur_stage), 32'd3);
    stage_sel = 4'd1; tick();
`ifdef AD9361_CAL_MON_LAT_EN
    check_val("lat_stage1", stage_lat, 32'd10);
`else
    check_val("lat_tied", stage_lat, 32'd0);
`endif

    // Early flags for later stages consumed one per cycle
    do_reset(1); wait_release();
    stage_done = 4'b1110; repeat (3) tick();
    stage_done = 4'b1111; tick(); stage_done = 4'b1110;
    check_val("early_cur1", 32'(cur_stage), 32'd1);
    tick(); tick();
    check_val("early_ok_wait", 32'(cfg_ok), 32'd0);
    tick();
    check_val("early_ok", 32'(cfg_ok), 32'd1);
    stage_done = '0;

    // Timeout, retry, second timeout -> FAIL
    do_reset(1); wait_release(); pulse(4'b0001);
    k = 0; while (resetb === 1'b1 && k < 150) begin tick(); k++; end
    check_val("retry_cnt1", 32'(retry_cnt), 32'd1);
    check_val("retry_led_clear", 32'(led), 32'd0);
    low = (resetb === 1'b0) ? 1 : 0;
    k = 0; while (resetb !== 1'b1 && k < 50) begin tick(); k++; if (resetb === 1'b0) low++; end
    check_val("retry_low_cycles", 32'(low), 32'd8);
    pulse(4'b0001);
    k = 0; while (cfg_err !== 1'b1 && k < 150) begin tick(); k++; end
    check_val("fail_err", 32'(cfg_err), 32'd1);
    check_val("fail_cur", 32'(cur_stage), 32'd1);
    check_val("fail_led0", 32'(led[0]), 32'd1);
    prev = led[1]; tog = 0;
    repeat (12) begin tick(); if (led[1] !== prev) tog++; prev = led[1]; end
    check_val("fail_blink_toggles", 32'(tog), 32'd3);

    // Hit on the final timer cycle beats the timeout
    do_reset(1); wait_release(); pulse(4'b0001);
    k = 0; while (m_timer != TO - 1 && k < 150) begin tick(); k++; end
    pulse(4'b0010);
    check_val("edge_hit_cur", 32'(cur_stage), 32'd2);
    check_val("edge_hit_retry", 32'(retry_cnt), 32'd0);

    // sys_rst during WAIT stage 2 after one retry
    do_reset(1); wait_release(); pulse(4'b0001);
    k = 0; while (retry_cnt !== 4'd1 && k < 150) begin tick(); k++; end
    wait_release(); pulse(4'b0001); pulse(4'b0010); repeat (5) tick();
    check_val("pre_rst_cur", 32'(cur_stage), 32'd2);
    sys_rst = 1'b1; tick();
    check_val("mid_rst_state", {resetb, spi_restart, cfg_ok, cfg_err, 4'(led), cur_stage, retry_cnt}, 32'd0);
    sys_rst = 1'b0; wait_release(); pulse(4'b0001);
    check_val("restart_cur", 32'(cur_stage), 32'd1);

    // Random stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NS; i++) stage_done[i] = ($urandom_range(0, 15) == 0);
      stage_sel = 4'($urandom_range(0, 5));
      sys_rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    sys_rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
